// File: rtl/pfb_ctrl_pkg.sv
// pfb_ctrl_pkg: shared types and helpers for the ADC-to-PFB frame controller
package pfb_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RUN, RESYNC, DRAIN} frame_ctrl_state_t;
  localparam int FFT_LEN_DEF = 64;
  localparam int IDX_W = $clog2(FFT_LEN_DEF);
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic [31:0] max);
    return (cnt == max) ? cnt : cnt + 32'd1;
  endfunction
endpackage

// File: rtl/frame_out_reg.sv
// frame_out_reg: 1-deep axis holding register between ADC capture and the PFB
module frame_out_reg #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          load,
  input  logic [DW-1:0] din,
  input  logic          din_last,
  input  logic          m_ready,
  output logic          full,
  output logic [DW-1:0] data,
  output logic          last
);
  // load wins over unload so a simultaneous load/unload keeps the slot occupied
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      full <= 1'b0;
      data <= '0;
      last <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
      data <= din;
      last <= din_last;
    end else if (m_ready) begin
      full <= 1'b0;
      last <= 1'b0;
    end
endmodule

// File: rtl/adc_frame_ctrl.sv
// adc_frame_ctrl: frames the free-running ADC stream into FFT_LEN-sample PFB frames (stats under `ADC_FRAME_CTRL_STATS_EN)
module adc_frame_ctrl
  import pfb_ctrl_pkg::*;
#(
  parameter int TWID    = 16,
  parameter int FFT_LEN = 64,
  parameter int NFRM_W  = 16,
  parameter int DROP_W  = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic                stop,
  input  logic [NFRM_W-1:0]   num_frames,
  output logic                adc_en,
  input  logic [2*TWID-1:0]   s_axis_tdata,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  output logic [2*TWID-1:0]   m_axis_tdata,
  output logic                m_axis_tvalid,
  output logic                m_axis_tlast,
  input  logic                m_axis_tready,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [NFRM_W-1:0]   frame_cnt,
  output logic [DROP_W-1:0]   drop_cnt
);
  localparam int IW = $clog2(FFT_LEN);
  frame_ctrl_state_t state, state_n;
  logic [IW-1:0] idx;
  logic [NFRM_W-1:0] nfrm, loaded;
  logic stop_pend, beat, wrap, load, drop, last_load, stop_n, hit, start_ok;
  assign s_axis_tready = state == RUN || state == RESYNC;
  assign adc_en = s_axis_tready;
  assign busy = state != IDLE;
  assign beat = s_axis_tvalid & s_axis_tready;
  assign wrap = idx == IW'(FFT_LEN - 1);
  assign load = beat && state == RUN && (!m_axis_tvalid || m_axis_tready);
  assign drop = beat && !load;
  assign last_load = load && wrap;
  assign stop_n = stop_pend | stop;
  assign hit = nfrm != '0 && (loaded + NFRM_W'(1)) == nfrm;
  assign start_ok = state == IDLE && start;
  frame_out_reg #(.DW(2*TWID)) u_out (
    .clk     (clk),
    .rstn    (rstn),
    .load    (load),
    .din     (s_axis_tdata),
    .din_last(wrap),
    .m_ready (m_axis_tready),
    .full    (m_axis_tvalid),
    .data    (m_axis_tdata),
    .last    (m_axis_tlast)
  );
  // next state: a frame only closes on its last sample, so DRAIN is entered at wrap points
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = start ? RUN : IDLE;
      RUN:     state_n = (last_load && (stop_n || hit)) ? DRAIN : drop ? RESYNC : RUN;
      RESYNC:  state_n = (beat && wrap) ? (stop_n ? DRAIN : RUN) : RESYNC;
      DRAIN:   state_n = m_axis_tvalid ? DRAIN : IDLE;
    endcase
  end
  // state register, sample index, frame bookkeeping and sticky overflow
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state     <= IDLE;
      idx       <= '0;
      nfrm      <= '0;
      loaded    <= '0;
      stop_pend <= 1'b0;
      overflow  <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= state_n;
      done  <= state == DRAIN && !m_axis_tvalid;
      if (start_ok) begin
        idx       <= '0;
        nfrm      <= num_frames;
        loaded    <= '0;
        stop_pend <= 1'b0;
        overflow  <= 1'b0;
      end else begin
        if (beat) idx <= idx + 1'b1;
        if (last_load) loaded <= loaded + NFRM_W'(1);
        if (drop) overflow <= 1'b1;
        stop_pend <= (state_n == IDLE) ? 1'b0 : stop_pend | (stop & s_axis_tready);
      end
    end
`ifdef ADC_FRAME_CTRL_STATS_EN
  // completed-frame and saturating drop statistics, restarted by an accepted start
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else if (start_ok) begin
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast) frame_cnt <= frame_cnt + NFRM_W'(1);
      if (drop) drop_cnt <= DROP_W'(sat_inc(32'(drop_cnt), 32'({DROP_W{1'b1}})));
    end
`else
  assign frame_cnt = '0;
  assign drop_cnt  = '0;
`endif
endmodule

// File: tb/tb_adc_frame_ctrl.sv
// tb_adc_frame_ctrl: randomized bench for adc_frame_ctrl against a queue-based reference model
module tb_adc_frame_ctrl;
  localparam int TWID = 16, L = 8, NW = 16, DWD = 16;
  logic clk = 1'b0, rstn = 1'b0, start = 1'b0, stop = 1'b0;
  logic [NW-1:0] num_frames = '0;
  logic adc_en, s_ready, m_valid, m_last, busy, done, overflow;
  logic s_valid = 1'b0, m_ready = 1'b1;
  logic [2*TWID-1:0] s_data = '0, m_data;
  logic [NW-1:0] frame_cnt;
  logic [DWD-1:0] drop_cnt;
  int pass_n = 0, total_n = 0, beats_seen = 0, tl_seen = 0;
  int md, midx, nfrm, loaded, frames, drops;
  bit mstop, ovf, mdone;
  logic [31:0] qd[$];
  bit ql[$];
  always #5 clk = ~clk;
  adc_frame_ctrl #(.TWID(TWID), .FFT_LEN(L), .NFRM_W(NW), .DROP_W(DWD)) dut (
    .clk(clk), .rstn(rstn), .start(start), .stop(stop), .num_frames(num_frames),
    .adc_en(adc_en), .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tready(s_ready),
    .m_axis_tdata(m_data), .m_axis_tvalid(m_valid), .m_axis_tlast(m_last), .m_axis_tready(m_ready),
    .busy(busy), .done(done), .overflow(overflow), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_n++;
    if (got === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask
  task automatic m_reset();
    md = 0; midx = 0; nfrm = 0; loaded = 0; frames = 0; drops = 0;
    mstop = 0; ovf = 0; mdone = 0;
    qd.delete(); ql.delete();
  endtask
  // md: 0 idle, 1 capturing, 2 discarding to next frame boundary, 3 flushing
  task automatic m_step();
    bit empty0, last;
    empty0 = qd.size() == 0;
    mdone = 0;
    if (!empty0 && m_ready) begin
      if (ql[0]) frames++;
      void'(qd.pop_front());
      void'(ql.pop_front());
    end
    if (md == 0) begin
      if (start) begin
        md = 1; nfrm = num_frames; midx = 0; loaded = 0; frames = 0; drops = 0; ovf = 0; mstop = 0;
      end
    end else if (md == 3) begin
      if (empty0) begin md = 0; mdone = 1; mstop = 0; end
    end else begin
      if (stop) mstop = 1;
      if (s_valid) begin
        last = midx == L - 1;
        if (md == 1 && (empty0 || m_ready)) begin
          qd.push_back(s_data);
          ql.push_back(last);
          if (last) begin
            loaded++;
            if (mstop || (nfrm != 0 && loaded == nfrm)) md = 3;
          end
        end else begin
          drops = drops < 65535 ? drops + 1 : drops;
          ovf = 1;
          if (md == 1) md = 2;
          else if (last) md = mstop ? 3 : 1;
        end
        midx = (midx + 1) % L;
      end
    end
  endtask
  task automatic cmp_all();
    chk("tvalid", m_valid, qd.size() > 0);
    if (qd.size() > 0) begin
      chk("tdata", m_data, qd[0]);
      chk("tlast", m_last, ql[0]);
    end
    chk("busy", busy, md != 0);
    chk("adc_en", adc_en, md == 1 || md == 2);
    chk("s_tready", s_ready, md == 1 || md == 2);
    chk("done", done, mdone);
    chk("overflow", overflow, ovf);
`ifdef ADC_FRAME_CTRL_STATS_EN
    chk("frame_cnt", frame_cnt, frames);
    chk("drop_cnt", drop_cnt, drops);
`else
    chk("frame_cnt", frame_cnt, 0);
    chk("drop_cnt", drop_cnt, 0);
`endif
  endtask
  task automatic tick();
    s_data = $urandom;
    if (m_valid && m_ready) begin
      beats_seen++;
      if (m_last) tl_seen++;
    end
    m_step();
    @(posedge clk);
    #1;
    cmp_all();
  endtask
  task automatic go(input int nf);
    num_frames = NW'(nf);
    start = 1'b1;
    beats_seen = 0;
    tl_seen = 0;
    tick();
    start = 1'b0;
  endtask
  task automatic run_idle(input int maxc);
    int n;
    n = 0;
    while (md != 0 && n < maxc) begin
      tick();
      n++;
    end
    chk("idle_in_budget", n < maxc, 1);
  endtask
  initial begin
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    cmp_all();
    rstn = 1'b1;
    tick();
    s_valid = 1'b1; m_ready = 1'b1;
    go(3);
    run_idle(200);
    chk("s1_beats", beats_seen, 24);
    chk("s1_tlast", tl_seen, 3);
    go(0);
    repeat (5) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    run_idle(200);
    chk("s2_beats", beats_seen, 8);
    chk("s2_tlast", tl_seen, 1);
    go(2);
    repeat (10) tick();
    m_ready = 1'b0;
    repeat (3) tick();
    m_ready = 1'b1;
    run_idle(200);
    chk("s3_overflow", overflow, 1);
    chk("s3_tlast", tl_seen, 2);
    s_valid = 1'b1; m_ready = 1'b1;
    go(2);
    for (int c = 0; c < 200 && md != 0; c++) begin
      s_valid = c[0] == 1'b0;
      m_ready = s_valid;
      tick();
    end
    s_valid = 1'b1; m_ready = 1'b1;
    run_idle(200);
    chk("s4_no_drop", overflow, 0);
    chk("s4_beats", beats_seen, 16);
    chk("s4_tlast", tl_seen, 2);
    go(0);
    repeat (5) tick();
    #2 rstn = 1'b0;
    #1;
    chk("s5_adc_en", adc_en, 0);
    chk("s5_tvalid", m_valid, 0);
    chk("s5_busy", busy, 0);
    chk("s5_frame_cnt", frame_cnt, 0);
    chk("s5_drop_cnt", drop_cnt, 0);
    m_reset();
    tick();
    rstn = 1'b1;
    go(1);
    run_idle(200);
    chk("s5_beats", beats_seen, 8);
    go(1);
    repeat (3) tick();
    num_frames = 5;
    start = 1'b1;
    tick();
    start = 1'b0;
    run_idle(200);
    chk("s6_busy_start", tl_seen, 1);
    stop = 1'b1;
    go(1);
    stop = 1'b0;
    run_idle(200);
    chk("s6_start_stop", tl_seen, 1);
    for (int r = 0; r < 6; r++) begin
      int k, nf;
      nf = $urandom_range(0, 3);
      k = $urandom_range(0, 50);
      go(nf);
      for (int c = 0; c < 80 && md != 0; c++) begin
        s_valid = $urandom_range(0, 9) < 8;
        m_ready = $urandom_range(0, 9) < 7;
        stop = c == k;
        tick();
      end
      stop = 1'b0; s_valid = 1'b1; m_ready = 1'b1;
      if (md != 0 && nf == 0) begin
        stop = 1'b1;
        tick();
        stop = 1'b0;
      end
      run_idle(300);
    end
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
